// File: rtl/starter_kit_pkg.sv
// Shared constants and the 7-segment glyph table for the starter-kit demo core.
package starter_kit_pkg;
  localparam int NUM_BTN = 9;
  localparam int NUM_SW  = 8;

  localparam int BTN_RUN  = 0;
  localparam int BTN_CLR  = 1;
  localparam int BTN_DIR  = 2;
  localparam int BTN_STEP = 3;
  localparam int BTN_ACK  = 8;

  localparam int SW_MODE   = 0;
  localparam int SW_LEDSEL = 1;

  localparam int KW4_SEG_LSB = 0;
  localparam int KW4_DP      = 7;
  localparam int KW4_DIG_LSB = 8;
  localparam int KW4_COLON   = 12;
  localparam int KW4_APOS    = 13;
  localparam logic [13:0] KW4_OFF = 14'h3FFF;

  // Active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction
endpackage

// File: rtl/starter_kit_debounce.sv
// Synchronizer plus per-bit debounce; emits the debounced level and a 1-cycle change pulse.
module starter_kit_debounce #(
  parameter int WIDTH           = 9,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] chg
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync[0] <= raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync[s] <= sync[s-1];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CW-1:0] cnt;
    logic          lvl;
    logic          pulse;
    logic          in;

    assign in       = sync[SYNC_STAGES-1][i];
    assign level[i] = lvl;
    assign chg[i]   = pulse;

    // Any cycle matching the current level restarts the stability count.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt   <= '0;
        lvl   <= 1'b0;
        pulse <= 1'b0;
      end else begin
        pulse <= 1'b0;
        if (in == lvl) begin
          cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt   <= '0;
          lvl   <= in;
          pulse <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/starter_kit_dut.sv
// Starter-kit demo core: 4-digit dec/hex up/down counter, scanned 7-seg display, LEDs, wrap IRQ.
module starter_kit_dut
  import starter_kit_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SCAN_CYCLES     = 2500,
  parameter int TICK_CYCLES     = 1000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [8:0]  BUTTON_pins,
  input  logic [7:0]  SWITCHE_pins,
  output logic [7:0]  LED_pins,
  output logic [13:0] KW4_56NCWB_P_Y_pins,
  output logic        INTR
);
  localparam int PW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SCW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  logic [NUM_BTN-1:0] btn_lvl, btn_chg, press;
  logic [NUM_SW-1:0]  sw_lvl, sw_chg;

  starter_kit_debounce #(.WIDTH(NUM_BTN), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
    u_btn (.clk(CLK), .rst(RST), .raw(BUTTON_pins), .level(btn_lvl), .chg(btn_chg));
  starter_kit_debounce #(.WIDTH(NUM_SW), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
    u_sw (.clk(CLK), .rst(RST), .raw(SWITCHE_pins), .level(sw_lvl), .chg(sw_chg));

  assign press = btn_chg & btn_lvl;

  logic            run, dir, hb;
  logic [PW-1:0]   presc;
  logic [3:0][3:0] count, stepped;
  logic [1:0]      scan_idx;
  logic [SCW-1:0]  scan_cnt;
  logic            mode, tick, step, clear, wrap;
  logic [3:0]      lim;

  assign mode  = sw_lvl[SW_MODE];
  assign tick  = run && (presc == PW'(TICK_CYCLES - 1));
  assign step  = tick || (press[BTN_STEP] && !run);
  assign clear = press[BTN_CLR] || sw_chg[SW_MODE];

  // Ripple carry/borrow across digits; wrap is the carry/borrow out of the MS digit.
  always_comb begin
    lim     = mode ? 4'hF : 4'd9;
    stepped = count;
    wrap    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (wrap) begin
        if (!dir) begin
          if (count[i] >= lim) stepped[i] = 4'd0;
          else begin stepped[i] = count[i] + 4'd1; wrap = 1'b0; end
        end else begin
          if (count[i] == 4'd0) stepped[i] = lim;
          else begin stepped[i] = count[i] - 4'd1; wrap = 1'b0; end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      run      <= 1'b0;
      dir      <= 1'b0;
      hb       <= 1'b0;
      presc    <= '0;
      count    <= '0;
      INTR     <= 1'b0;
      scan_idx <= '0;
      scan_cnt <= '0;
      LED_pins <= '0;
      KW4_56NCWB_P_Y_pins <= KW4_OFF;
    end else begin
      if (press[BTN_RUN]) run <= ~run;
      if (press[BTN_DIR]) dir <= ~dir;
      if (tick) hb <= ~hb;

      if (clear) begin
        count <= '0;
        presc <= '0;
      end else begin
        if (run) presc <= tick ? '0 : presc + 1'b1;
        if (step) count <= stepped;
      end

      // A step dropped by a simultaneous clear must not raise the interrupt.
      if (step && wrap && !clear) INTR <= 1'b1;
      else if (press[BTN_ACK])    INTR <= 1'b0;

      if (scan_cnt == SCW'(SCAN_CYCLES - 1)) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      LED_pins <= sw_lvl[SW_LEDSEL] ? {count[1], count[0]}
                                    : {btn_lvl[7:4], run, dir, INTR, hb};
      KW4_56NCWB_P_Y_pins <= {~dir, ~run, ~(4'b0001 << scan_idx), 1'b1, seg7(count[scan_idx])};
    end
  end
endmodule

// File: tb/tb_starter_kit_dut.sv
// Randomized self-checking bench for starter_kit_dut against a value-level counter model.
module tb_starter_kit_dut;
  localparam int DEB = 4, SCAN = 8, TICK = 10;
  localparam int OP_STEP = 0, OP_DIR = 1, OP_MODE = 2, OP_CLR = 3, OP_ACK = 4, OP_GLITCH = 5;

  logic        clk = 1'b0, rst = 1'b1;
  logic [8:0]  btn = '0;
  logic [7:0]  sw  = '0;
  logic [7:0]  led;
  logic [13:0] kw;
  logic        intr;

  int vec_cnt = 0, err_cnt = 0;
  int m_cnt = 0;
  bit m_run = 0, m_dir = 0, m_mode = 0, m_intr = 0;
  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int glitch_btn [5] = '{0, 1, 2, 3, 8};

  starter_kit_dut #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB), .SCAN_CYCLES(SCAN), .TICK_CYCLES(TICK)) dut (
    .CLK(clk), .RST(rst), .BUTTON_pins(btn), .SWITCHE_pins(sw),
    .LED_pins(led), .KW4_56NCWB_P_Y_pins(kw), .INTR(intr));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int cnt_range();
    return m_mode ? 65536 : 10000;
  endfunction

  function automatic int digit(input int k);
    int v = m_cnt;
    if (m_mode) return (v >> (4 * k)) & 15;
    for (int i = 0; i < k; i++) v = v / 10;
    return v % 10;
  endfunction

  task automatic model_step();
    if (!m_dir) begin
      if (m_cnt == cnt_range() - 1) begin m_cnt = 0; m_intr = 1; end
      else m_cnt++;
    end else begin
      if (m_cnt == 0) begin m_cnt = cnt_range() - 1; m_intr = 1; end
      else m_cnt--;
    end
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1; cyc(10);
    btn[b] = 1'b0; cyc(12);
  endtask

  task automatic op(input int kind);
    case (kind)
      OP_STEP: begin press(3); if (!m_run) model_step(); end
      OP_DIR:  begin press(2); m_dir = !m_dir; end
      OP_MODE: begin sw[0] = ~sw[0]; cyc(14); m_mode = !m_mode; m_cnt = 0; end
      OP_CLR:  begin press(1); m_cnt = 0; end
      OP_ACK:  begin press(8); m_intr = 0; end
      default: begin
        int b = glitch_btn[$urandom_range(0, 4)];
        btn[b] = 1'b1; cyc(2);
        btn[b] = 1'b0; cyc(12);
      end
    endcase
  endtask

  task automatic check_state(input string tag);
    logic [3:0] seen = '0;
    logic [3:0] en;
    @(negedge clk);
    chk({tag, ":intr"},  intr, m_intr);
    chk({tag, ":led"},   led, (digit(1) << 4) | digit(0));
    chk({tag, ":colon"}, kw[12], !m_run);
    chk({tag, ":apos"},  kw[13], !m_dir);
    for (int c = 0; c < 4 * SCAN + 4; c++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        en = ~(4'b0001 << d);
        if (kw[11:8] == en && !seen[d]) begin
          seen[d] = 1'b1;
          chk($sformatf("%s:dig%0d", tag, d), kw[7:0], seg_tbl[digit(d)]);
        end
      end
    end
    chk({tag, ":scan"}, seen, 4'hF);
  endtask

  initial begin
    int v0, v1;
    logic h0;
    logic [3:0] pat;

    // Reset values
    cyc(5);
    @(negedge clk);
    chk("rst_led", led, 8'h00);
    chk("rst_kw", kw, 14'h3FFF);
    chk("rst_intr", intr, 1'b0);
    rst = 1'b0; cyc(2);
    @(negedge clk);
    chk("post_rst_kw", kw, 14'h3EC0);

    sw[1] = 1'b1; cyc(14);
    check_state("init");
    op(OP_GLITCH); check_state("glitch");

    // Decimal wrap both ways
    op(OP_DIR); op(OP_STEP); check_state("dec_down_wrap");
    op(OP_ACK); check_state("dec_ack");
    op(OP_DIR); op(OP_STEP); check_state("dec_up_wrap");
    op(OP_ACK);

    // Hex down wrap shows FFFF
    op(OP_MODE); check_state("hex_mode");
    op(OP_DIR); op(OP_STEP); check_state("hex_down_wrap");
    op(OP_ACK); op(OP_DIR);

    for (int i = 0; i < 30; i++) begin
      int r = $urandom_range(0, 7);
      op(r <= 2 ? OP_STEP : r - 2);
      check_state($sformatf("rnd%0d", i));
    end

    // Free-running count and heartbeat
    op(OP_CLR);
    if (m_dir) op(OP_DIR);
    press(0); m_run = 1;
    @(negedge clk);
    chk("run_colon", kw[12], 1'b0);
    v0 = m_mode ? led : led[7:4] * 10 + led[3:0];
    repeat (3 * TICK) @(negedge clk);
    v1 = m_mode ? led : led[7:4] * 10 + led[3:0];
    chk("run_advance", v1, (v0 + 3) % (m_mode ? 256 : 100));
    sw[1] = 1'b0; cyc(14);
    @(negedge clk);
    h0 = led[0];
    chk("led_status", led[7:1], {4'b0000, 1'b1, m_dir, m_intr});
    repeat (TICK) @(negedge clk);
    chk("hb_toggle1", led[0], !h0);
    repeat (TICK) @(negedge clk);
    chk("hb_toggle2", led[0], h0);
    pat = 4'($urandom_range(1, 15));
    btn[7:4] = pat; cyc(14);
    @(negedge clk);
    chk("led_btn_hi", led[7:4], pat);
    btn[7:4] = '0; cyc(12);
    press(0); m_run = 0;
    sw[1] = 1'b1; cyc(14);
    op(OP_CLR); check_state("run_stop");

    // Clear before, together with, and after the wrapping tick
    for (int p = TICK - 1; p <= TICK + 1; p++) begin
      op(OP_CLR); op(OP_DIR); op(OP_STEP); check_state($sformatf("pre%0d", p));
      op(OP_DIR); op(OP_ACK);
      for (int c = 0; c < p + 30; c++) begin
        btn[0] = (c < 8) || (c >= p + 5 && c < p + 15);
        btn[1] = (c >= p) && (c < p + 10);
        cyc(1);
      end
      btn[1:0] = '0; cyc(12);
      // The first tick lands TICK cycles after run is toggled on.
      m_cnt = 0;
      m_intr = (p > TICK);
      check_state($sformatf("tickclr%0d", p));
      if (m_intr) op(OP_ACK);
    end

    // Reset in the middle of operation
    op(OP_DIR); op(OP_STEP);
    rst = 1'b1; cyc(2);
    @(negedge clk);
    chk("mid_rst_led", led, 8'h00);
    chk("mid_rst_kw", kw, 14'h3FFF);
    chk("mid_rst_intr", intr, 1'b0);
    rst = 1'b0; cyc(14);
    m_cnt = 0; m_dir = 0; m_run = 0; m_intr = 0;
    check_state("after_mid_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
